// File: rtl/systolic_skew_feeder.sv
// Vector buffer feeding a systolic array edge: lane l is delayed by l cycles so that
// element buf[t-l][l] appears at step t. Streams len vectors reps times, back to back.
module systolic_skew_feeder #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_valid_i,
  input  logic [N*DATA_WIDTH-1:0]      wr_data_i,
  output logic                         wr_ready_o,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [$clog2(DEPTH+1)-1:0]   len_i,
  input  logic [7:0]                   reps_i,
  input  logic                         stall_i,
  output logic [N*DATA_WIDTH-1:0]      data_o,
  output logic [N-1:0]                 lane_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(DEPTH + N);
  localparam int unsigned VW = N * DATA_WIDTH;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [FW-1:0]   len_q, len_d;
  logic [7:0]      reps_q, reps_d;
  logic [7:0]      pass_q, pass_d;
  logic [TW-1:0]   step_q, step_d;
  logic [VW-1:0]   data_q, data_d;
  logic [N-1:0]    valid_q, valid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [VW-1:0]   buf_q [DEPTH];

  logic            load;
  logic            emit;
  logic [TW-1:0]   step_sel;
  logic [FW-1:0]   len_sel;
  logic [TW-1:0]   last_step;
  logic [VW-1:0]   lane_data;
  logic [N-1:0]    lane_valid;
  int              diff;

  assign wr_ready_o = (state_q == StIdle) && (fill_q < FW'(DEPTH));
  assign load       = wr_ready_o && wr_valid_i && !clear_i;
  assign last_step  = TW'(int'(len_q) + int'(N) - 2);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    len_d    = len_q;
    reps_d   = reps_q;
    pass_d   = pass_q;
    step_d   = step_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    emit     = 1'b0;
    step_sel = step_q;
    len_sel  = len_q;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          fill_d = '0;
        end else if (load) begin
          fill_d = fill_q + FW'(1);
        end
        // Length is judged against the fill level before any same-cycle load.
        if (start_i) begin
          if (len_i == '0 || len_i > fill_q) begin
            err_d = 1'b1;
          end else begin
            state_d  = StStream;
            len_d    = len_i;
            reps_d   = (reps_i == 8'd0) ? 8'd1 : reps_i;
            pass_d   = 8'd0;
            step_d   = '0;
            step_sel = '0;
            len_sel  = len_i;
            emit     = 1'b1;
          end
        end
      end
      StStream: begin
        if (!stall_i) begin
          if (step_q == last_step) begin
            if (pass_q == reps_q - 8'd1) begin
              state_d = StIdle;
              data_d  = '0;
              valid_d = '0;
              done_d  = 1'b1;
              step_d  = '0;
              pass_d  = 8'd0;
            end else begin
              pass_d   = pass_q + 8'd1;
              step_d   = '0;
              step_sel = '0;
              emit     = 1'b1;
            end
          end else begin
            step_d   = step_q + TW'(1);
            step_sel = step_q + TW'(1);
            emit     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (emit) begin
      data_d  = lane_data;
      valid_d = lane_valid;
    end
  end

  // Skew: lane l shows vector (step - l) when that index lies inside the pass.
  always_comb begin
    lane_data  = '0;
    lane_valid = '0;
    diff       = 0;
    for (int l = 0; l < int'(N); l++) begin
      diff = int'(step_sel) - l;
      if (diff >= 0 && diff < int'(len_sel)) begin
        lane_valid[l] = 1'b1;
        lane_data[l*DATA_WIDTH +: DATA_WIDTH] = buf_q[AW'(diff)][l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      fill_q  <= '0;
      len_q   <= '0;
      reps_q  <= 8'd0;
      pass_q  <= 8'd0;
      step_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      len_q   <= len_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
      step_q  <= step_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load) begin
      buf_q[fill_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign data_o       = data_q;
  assign lane_valid_o = valid_q;
  assign busy_o       = (state_q == StStream);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign fill_o       = fill_q;

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 8: lane count, equal to the systolic array edge size.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per lane element.
REQ-003 SHALL have parameter DEPTH, default 16: vector buffer capacity, DEPTH >= 1.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_valid_i, input, 1 bit: a load vector is offered.
REQ-007 SHALL have port wr_data_i, input, N*DATA_WIDTH bits: load vector; lane l occupies bits [l*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port wr_ready_o, output, 1 bit: a load vector is accepted when wr_valid_i and wr_ready_o are both high.
REQ-009 SHALL have port clear_i, input, 1 bit: empty the buffer.
REQ-010 SHALL have port start_i, input, 1 bit: request a stream.
REQ-011 SHALL have port len_i, input, $clog2(DEPTH+1) bits: vectors per pass.
REQ-012 SHALL have port reps_i, input, 8 bits: pass count; 0 is treated as 1.
REQ-013 SHALL have port stall_i, input, 1 bit: freeze streaming.
REQ-014 SHALL have port data_o, output, N*DATA_WIDTH bits: skewed output with the same lane packing as wr_data_i, registered.
REQ-015 SHALL have port lane_valid_o, output, N bits: per-lane valid, registered.
REQ-016 SHALL have port busy_o, output, 1 bit: high while in STREAM.
REQ-017 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port err_o, output, 1 bit: one-cycle pulse on a rejected start.
REQ-019 SHALL have port fill_o, output, $clog2(DEPTH+1) bits: number of stored vectors.

Function
REQ-020 SHALL implement FSM states IDLE and STREAM.
REQ-021 SHALL drive wr_ready_o = (state==IDLE) && (fill_o<DEPTH); loads are stored at index fill_o, and fill_o increments by one per accepted load.
REQ-022 SHALL, when clear_i is high in IDLE, set fill_o to 0 and accept no load that cycle; clear_i SHALL be ignored in STREAM.
REQ-023 SHALL, in IDLE with start_i high, check len_i against the fill_o value at the start of that cycle; a load accepted in the same cycle SHALL still be stored.
REQ-024 SHALL, on a start with len_i==0 or len_i>fill_o, pulse err_o the next cycle and stay in IDLE.
REQ-025 SHALL, on an accepted start, latch len_i and reps_i, enter STREAM, and reset the pass counter p=0 and the step counter t=0.
REQ-026 SHALL present, in each non-stalled STREAM cycle, lane l with buf[t-l][l] and lane_valid_o[l]=1 when 0<=t-l<len; otherwise lane l SHALL be 0 with lane_valid_o[l]=0.
REQ-027 SHALL place the first output (t=0) in the cycle after start is accepted.
REQ-028 SHALL make each pass len+N-1 cycles long; at t==len+N-2, t SHALL wrap to 0 and p SHALL increment, with no gap between passes.
REQ-029 SHALL, while stall_i is high in STREAM, hold t, p, data_o and lane_valid_o unchanged.
REQ-030 SHALL, after the last step of the last pass, return to IDLE in the next cycle with data_o=0, lane_valid_o=0, busy_o=0 and done_o=1 for exactly that cycle.
REQ-031 SHALL ignore start_i while in STREAM.
REQ-032 SHALL retain buffer contents and fill_o after done, so a stream can be replayed without reloading.
REQ-033 SHALL set the total stream duration to reps*(len+N-1) cycles plus the number of stall cycles.

Reset
REQ-034 SHALL, when rst_i is high at a clock edge, including mid-stream, put the next-cycle state in IDLE with fill_o=0, data_o=0, lane_valid_o=0, busy_o=0, done_o=0, err_o=0, wr_ready_o=1, and counters at 0.
REQ-035 SHALL NOT require buffer contents to be reset.

Verification (N=4, DATA_WIDTH=8, DEPTH=8; vector r lane l = 16r+l)
REQ-036 SHALL cover: load 3 vectors, start len=3 reps=1 -> 6 stream cycles; step0 lane0=0x00 only valid; step1 lanes0,1=0x10,0x01; step2 lanes0..2=0x20,0x11,0x02; step5 lane3=0x23 only valid; done_o in the 7th cycle after start.
REQ-037 SHALL cover: the same stream with stall_i high for 2 cycles at step 2 -> step-2 outputs held 3 cycles, done_o in the 9th cycle after start.
REQ-038 SHALL cover: fill_o=3, start len=5 -> err_o pulse, busy_o stays 0, fill_o=3.
REQ-039 SHALL cover: 9 back-to-back loads -> wr_ready_o=0 after the 8th, fill_o=8, the 9th vector is not stored.
REQ-040 SHALL cover: len=2 reps=2 -> 10 contiguous cycles, pass 2 identical to pass 1, a single done_o.
REQ-041 SHALL cover: rst_i at step 3 -> next cycle busy_o=0, lane_valid_o=0, fill_o=0, and no done_o.
